instr_decoder: RTL

INSTR_DECODER -- requirements
Module: instr_decoder

---
 rtl/instr_decoder_pkg.sv | 81 ++++++++
 rtl/instr_decoder.sv | 116 +++++++++++
 2 files changed

// File: rtl/instr_decoder_pkg.sv
// Shared definitions for the control unit, execution unit and ALU:
// opcode map, instruction field positions, FSM encoding and the decode function.
package instr_decoder_pkg;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int DST_MSB = 11;
  localparam int DST_LSB = 9;
  localparam int SRC_MSB = 8;
  localparam int SRC_LSB = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes 0..OP_ALU_LAST are all ALU operations.
  localparam logic [3:0] OP_ALU_LAST = 4'hA;
  localparam logic [3:0] OP_MOV      = 4'hB;
  localparam logic [3:0] OP_LDI      = 4'hC;
  localparam logic [3:0] OP_RDR      = 4'hD;
  localparam logic [3:0] OP_NOP      = 4'hE;
  localparam logic [3:0] OP_HALT     = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic       rd;
    logic       wr;
    logic [2:0] ade_bus;
    logic [2:0] ad_mov;
    logic [7:0] idt_bus;
  } eu_ctrl_t;

  localparam eu_ctrl_t EU_IDLE = '{opcode: OP_NOP, rd: 1'b0, wr: 1'b0,
                                   ade_bus: 3'd0, ad_mov: 3'd0, idt_bus: 8'd0};

  function automatic logic is_alu(input logic [3:0] op);
    return op <= OP_ALU_LAST;
  endfunction

  // ALU and RDR need a WAIT cycle for the execution unit to produce result.
  function automatic logic needs_wait(input logic [3:0] op);
    return is_alu(op) || (op == OP_RDR);
  endfunction

  function automatic eu_ctrl_t decode_ctrl(input logic [15:0] instr);
    eu_ctrl_t   c;
    logic [3:0] op;
    op = instr[OP_MSB:OP_LSB];
    c  = EU_IDLE;
    if (is_alu(op)) begin
      c.opcode = op;
    end else begin
      case (op)
        OP_MOV: begin
          c.opcode  = OP_MOV;
          c.ade_bus = instr[DST_MSB:DST_LSB];
          c.ad_mov  = instr[SRC_MSB:SRC_LSB];
        end
        OP_LDI: begin
          c.wr      = 1'b1;
          c.ade_bus = instr[DST_MSB:DST_LSB];
          c.idt_bus = instr[IMM_MSB:IMM_LSB];
        end
        OP_RDR: begin
          c.rd      = 1'b1;
          c.ade_bus = instr[DST_MSB:DST_LSB];
        end
        default: c = EU_IDLE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Instruction fetch/decode control unit: fetches words by pc, decodes them and
// drives one EXEC cycle of execution-unit controls, capturing results after WAIT.
module instr_decoder
  import instr_decoder_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk_cu,
  input  logic               rst,
  input  logic               start,
  output logic               instr_req,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic [3:0]         opcode,
  output logic               rd,
  output logic               wr,
  output logic [2:0]         ade_bus,
  output logic [2:0]         ad_mov,
  output logic [7:0]         idt_bus,
  input  logic [8:0]         result,
  input  logic [1:0]         flag,
  output logic [8:0]         acc_out,
  output logic [1:0]         flag_out,
  output logic               busy,
  output logic               halted,
  output state_t             state_o
);

  state_t             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [INSTR_W-1:0] instr_q;
  eu_ctrl_t           ctrl_q;
  eu_ctrl_t           dec;
  logic [3:0]         op;
  logic [8:0]         acc_q;
  logic [1:0]         flag_q;

  assign op   = instr_q[OP_MSB:OP_LSB];
  assign dec  = decode_ctrl(instr_q[15:0]);
  assign pc_d = pc_q + PC_W'(1);

  // Fetch handshake: instr_data is taken on a rising edge where instr_req and
  // instr_valid are both 1; instr_valid while instr_req is 0 is ignored.
  always_ff @(posedge clk_cu or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      ctrl_q  <= EU_IDLE;
      acc_q   <= '0;
      flag_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (instr_valid) begin
            instr_q <= instr_data;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (op == OP_HALT) begin
            state_q <= ST_HALT;
          end else begin
            ctrl_q  <= dec;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          pc_q <= pc_d;
          if (needs_wait(op)) begin
            // Bus selects stay put through WAIT; only the strobes drop.
            ctrl_q.rd <= 1'b0;
            ctrl_q.wr <= 1'b0;
            state_q   <= ST_WAIT;
          end else begin
            ctrl_q  <= EU_IDLE;
            state_q <= ST_FETCH;
          end
        end
        ST_WAIT: begin
          acc_q <= result;
          if (is_alu(op)) flag_q <= flag;
          ctrl_q  <= EU_IDLE;
          state_q <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_req = (state_q == ST_FETCH);
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                     (state_q == ST_EXEC)  || (state_q == ST_WAIT);
  assign halted    = (state_q == ST_HALT);
  assign state_o   = state_q;
  assign pc        = pc_q;
  assign opcode    = ctrl_q.opcode;
  assign rd        = ctrl_q.rd;
  assign wr        = ctrl_q.wr;
  assign ade_bus   = ctrl_q.ade_bus;
  assign ad_mov    = ctrl_q.ad_mov;
  assign idt_bus   = ctrl_q.idt_bus;
  assign acc_out   = acc_q;
  assign flag_out  = flag_q;

endmodule
